// File: rtl/tree_light_sequencer_if.sv
// Command/status bundle for the tree light sequencer.
// The bench drives through master; the sequencer consumes through slave.
interface tree_light_sequencer_if;
  logic       ena;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] speed;
  logic [7:0] leds;
  logic       busy;
  logic [2:0] step;
  logic       frame_done;

  modport master (output ena, start, stop, mode, speed,
                  input  leds, busy, step, frame_done);
  modport slave  (input  ena, start, stop, mode, speed,
                  output leds, busy, step, frame_done);
endinterface

// File: rtl/tree_light_sequencer.sv
// IDLE/RUN/PAUSE LED animation sequencer with a speed-scaled prescaler,
// 8-step pattern counter and an 8-bit LFSR for the twinkle pattern.
module tree_light_sequencer #(
  parameter int DIV_W = 20
) (
  input logic                    clk,
  input logic                    rst_n,
  tree_light_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, pm1;
  logic [DIV_W:0]   p_full;
  logic [2:0]       step_q, step_d;
  logic [7:0]       lfsr_q, lfsr_d, leds_q, leds_d;
  logic             fd_q, fd_d, tick;

  // P-1 where P = (speed+1) << (DIV_W-4); one extra bit so speed=15 at the
  // top of the range wraps to all-ones rather than overflowing.
  always_comb begin
    p_full = ({{(DIV_W-3){1'b0}}, bus.speed} + {{DIV_W{1'b0}}, 1'b1}) << (DIV_W-4);
    pm1    = p_full[DIV_W-1:0] - {{(DIV_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    lfsr_d  = lfsr_q;
    fd_d    = fd_q;
    tick    = 1'b0;
    if (bus.ena) begin
      fd_d = 1'b0;
      case (state_q)
        IDLE: if (bus.start && !bus.stop) begin
          state_d = RUN;
          cnt_d   = '0;
          step_d  = '0;
        end
        // A stop cycle freezes the animation where it stands, even on a tick.
        RUN: if (bus.stop) begin
          state_d = PAUSE;
        end else begin
          tick = (cnt_q >= pm1);
          if (tick) begin
            cnt_d  = '0;
            step_d = step_q + 3'd1;
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            fd_d   = (step_q == 3'd7);
          end else begin
            cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
          end
        end
        PAUSE: if (bus.stop) begin
          state_d = IDLE;
          cnt_d   = '0;
          step_d  = '0;
        end else if (bus.start) begin
          state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // LEDs are built from next-state values so they line up with step.
  always_comb begin
    case (bus.mode)
      2'd0:    leds_d = 8'd1 << step_d;
      2'd1:    leds_d = 8'hFF >> (3'd7 - step_d);
      2'd2:    leds_d = lfsr_d;
      default: leds_d = {8{step_d[0]}};
    endcase
    if (state_d == IDLE) leds_d = 8'h00;
    if (!bus.ena)        leds_d = leds_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      lfsr_q  <= 8'hA5;
      leds_q  <= 8'h00;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      lfsr_q  <= lfsr_d;
      leds_q  <= leds_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.leds       = leds_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.step       = step_q;
  assign bus.frame_done = fd_q;
endmodule

// File: tb/tb_tree_light_sequencer.sv
// Directed bench for tree_light_sequencer at DIV_W=4.
module tb_tree_light_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  tree_light_sequencer_if bus ();
  tree_light_sequencer #(.DIV_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; cyc(); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
  endtask

  function automatic logic [7:0] lfsr_nx(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.leds !== 8'h00) begin errors++; $display("FAIL reset_leds got %h want 00", bus.leds); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.step !== 3'd0) begin errors++; $display("FAIL reset_step got %0d want 0", bus.step); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got %b want 0", bus.frame_done); end
    rst_n = 1'b1;
    repeat (3) cyc();
    checks++; if (bus.busy !== 1'b0 || bus.leds !== 8'h00) begin errors++; $display("FAIL post_reset_idle busy %b leds %h want 0 00", bus.busy, bus.leds); end
  endtask

  task automatic test_chase();
    int s;
    bus.mode = 2'd0; bus.speed = 4'd0;
    pulse_start();
    checks++; if (bus.leds !== 8'h01 || bus.busy !== 1'b1) begin errors++; $display("FAIL chase_start leds %h busy %b want 01 1", bus.leds, bus.busy); end
    for (int i = 1; i <= 16; i++) begin
      cyc();
      s = i % 8;
      checks++; if (bus.step !== 3'(s) || bus.leds !== (8'd1 << s)) begin errors++; $display("FAIL chase_step%0d step %0d leds %h want %0d %h", i, bus.step, bus.leds, s, 8'd1 << s); end
      checks++; if (bus.frame_done !== (s == 0)) begin errors++; $display("FAIL chase_fd%0d got %b want %b", i, bus.frame_done, s == 0); end
    end
    pulse_stop(); pulse_stop();
    checks++; if (bus.busy !== 1'b0 || bus.leds !== 8'h00) begin errors++; $display("FAIL chase_idle busy %b leds %h want 0 00", bus.busy, bus.leds); end
  endtask

  task automatic test_fill();
    int s;
    logic [7:0] fill_tbl [8] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};
    bus.mode = 2'd1; bus.speed = 4'd2;
    pulse_start();
    for (int k = 0; k < 27; k++) begin
      if (k > 0) cyc();
      s = (k / 3) % 8;
      checks++; if (bus.step !== 3'(s) || bus.leds !== fill_tbl[s]) begin errors++; $display("FAIL fill_k%0d step %0d leds %h want %0d %h", k, bus.step, bus.leds, s, fill_tbl[s]); end
    end
    pulse_stop(); pulse_stop();
  endtask

  task automatic test_pause_resume();
    bus.mode = 2'd0; bus.speed = 4'd3;
    pulse_start();
    repeat (21) cyc();
    checks++; if (bus.step !== 3'd5) begin errors++; $display("FAIL pause_pre step %0d want 5", bus.step); end
    pulse_stop();
    repeat (3) cyc();
    checks++; if (bus.step !== 3'd5 || bus.leds !== 8'h20 || bus.busy !== 1'b1) begin errors++; $display("FAIL pause_hold step %0d leds %h busy %b want 5 20 1", bus.step, bus.leds, bus.busy); end
    pulse_start();
    cyc(); cyc();
    checks++; if (bus.step !== 3'd5) begin errors++; $display("FAIL resume_remain step %0d want 5", bus.step); end
    cyc();
    checks++; if (bus.step !== 3'd6 || bus.leds !== 8'h40) begin errors++; $display("FAIL resume_step step %0d leds %h want 6 40", bus.step, bus.leds); end
    pulse_stop(); pulse_stop();
    checks++; if (bus.busy !== 1'b0 || bus.leds !== 8'h00 || bus.step !== 3'd0) begin errors++; $display("FAIL pause_to_idle busy %b leds %h step %0d want 0 00 0", bus.busy, bus.leds, bus.step); end
  endtask

  task automatic test_speed_change();
    bus.mode = 2'd0; bus.speed = 4'd15;
    pulse_start();
    repeat (10) cyc();
    checks++; if (bus.step !== 3'd0) begin errors++; $display("FAIL slow_hold step %0d want 0", bus.step); end
    bus.speed = 4'd3;
    cyc();
    checks++; if (bus.step !== 3'd1 || bus.leds !== 8'h02) begin errors++; $display("FAIL speed_drop_tick step %0d leds %h want 1 02", bus.step, bus.leds); end
    repeat (3) cyc();
    checks++; if (bus.step !== 3'd1) begin errors++; $display("FAIL speed_new_hold step %0d want 1", bus.step); end
    cyc();
    checks++; if (bus.step !== 3'd2) begin errors++; $display("FAIL speed_new_tick step %0d want 2", bus.step); end
    pulse_stop(); pulse_stop();
  endtask

  task automatic test_collision_ena();
    bus.mode = 2'd0; bus.speed = 4'd0;
    pulse_start();
    repeat (3) cyc();
    bus.start = 1'b1; bus.stop = 1'b1;
    cyc();
    bus.start = 1'b0; bus.stop = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.step !== 3'd3 || bus.leds !== 8'h08) begin errors++; $display("FAIL collision busy %b step %0d leds %h want 1 3 08", bus.busy, bus.step, bus.leds); end
    cyc();
    checks++; if (bus.step !== 3'd3) begin errors++; $display("FAIL collision_paused step %0d want 3", bus.step); end
    pulse_start();
    cyc();
    checks++; if (bus.step !== 3'd4) begin errors++; $display("FAIL collision_resume step %0d want 4", bus.step); end
    bus.ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.stop  = (i == 2) || (i == 3);
      bus.start = (i == 5);
      cyc();
      checks++; if (bus.step !== 3'd4 || bus.leds !== 8'h10 || bus.busy !== 1'b1) begin errors++; $display("FAIL ena_hold%0d step %0d leds %h busy %b want 4 10 1", i, bus.step, bus.leds, bus.busy); end
    end
    bus.stop = 1'b0; bus.start = 1'b0; bus.ena = 1'b1;
    cyc();
    checks++; if (bus.step !== 3'd5 || bus.leds !== 8'h20) begin errors++; $display("FAIL ena_release step %0d leds %h want 5 20", bus.step, bus.leds); end
    pulse_stop(); pulse_stop();
    bus.ena = 1'b0;
    pulse_start();
    cyc();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ena_idle_start busy %b want 0", bus.busy); end
    bus.ena = 1'b1;
  endtask

  task automatic test_twinkle();
    logic [7:0] m;
    int early;
    early = 0;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    cyc();
    bus.mode = 2'd2; bus.speed = 4'd0;
    pulse_start();
    m = 8'hA5;
    checks++; if (bus.leds !== m) begin errors++; $display("FAIL twinkle_seed got %h want a5", bus.leds); end
    for (int i = 1; i <= 255; i++) begin
      cyc();
      m = lfsr_nx(m);
      if (i < 255 && bus.leds === 8'hA5) early++;
      checks++; if (bus.leds !== m || bus.leds === 8'h00) begin errors++; $display("FAIL twinkle_t%0d got %h want %h", i, bus.leds, m); end
    end
    checks++; if (early !== 0 || bus.leds !== 8'hA5) begin errors++; $display("FAIL twinkle_period early %0d leds %h want 0 a5", early, bus.leds); end
    pulse_stop(); pulse_stop();
  endtask

  task automatic test_async_reset();
    bus.mode = 2'd0; bus.speed = 4'd0;
    pulse_start();
    repeat (7) cyc();
    checks++; if (bus.step !== 3'd7 || bus.leds !== 8'h80) begin errors++; $display("FAIL areset_pre step %0d leds %h want 7 80", bus.step, bus.leds); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (bus.leds !== 8'h00 || bus.busy !== 1'b0 || bus.step !== 3'd0) begin errors++; $display("FAIL areset_now leds %h busy %b step %0d want 00 0 0", bus.leds, bus.busy, bus.step); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (bus.frame_done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL areset_after%0d fd %b busy %b want 0 0", i, bus.frame_done, bus.busy); end
    end
  endtask

  initial begin
    bus.ena = 1'b1; bus.start = 1'b0; bus.stop = 1'b0;
    bus.mode = 2'd0; bus.speed = 4'd0;
    rst_n = 1'b0;
    test_reset();
    test_chase();
    test_fill();
    test_pause_resume();
    test_speed_change();
    test_collision_ena();
    test_twinkle();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
